// File: rtl/read_stage.sv
// Operand-read pipeline stage: register-file read with writeback bypass, branch
// target/condition evaluation, and a single-entry valid/ready output register.
module read_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 5,
  parameter int SH_W   = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  // upstream
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  // decode
  input  logic                  imm_en,
  input  logic [IMM_W-1:0]      arg_imm,
  input  logic                  read_a,
  input  logic [REG_W-1:0]      arg_a,
  input  logic                  read_b,
  input  logic [REG_W-1:0]      arg_b,
  input  logic [2:0]            cmp_b,
  input  logic                  pc_set,
  input  logic                  pc_add,
  input  logic                  pc_inc,
  input  logic [1:0]            pc_src,
  input  logic [1:0]            en_regs,
  input  logic                  i_alu_en,
  input  logic [3:0]            i_truth_table,
  input  logic [4:0]            i_alu_op,
  input  logic                  sh_off_imm,
  // register file
  output logic                  reg_a_read,
  output logic [REG_W-1:0]      reg_a,
  input  logic [DATA_W-1:0]     reg_a_value,
  output logic                  reg_b_read,
  output logic [REG_W-1:0]      reg_b,
  input  logic [DATA_W-1:0]     reg_b_value,
  // writeback bypass
  input  logic                  wb_en,
  input  logic [REG_W-1:0]      wb_reg,
  input  logic [DATA_W-1:0]     wb_value,
  // downstream
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  src_a_en,
  output logic                  src_b_en,
  output logic [DATA_W-1:0]     src_a,
  output logic [DATA_W-1:0]     src_b,
  output logic                  o_alu_en,
  output logic [3:0]            o_truth_table,
  output logic [4:0]            o_alu_op,
  output logic [SH_W-1:0]       sh_off,
  // branch
  output logic                  o_pc_set,
  output logic                  o_pc_add,
  output logic                  o_pc_inc,
  output logic [2*DATA_W-2:0]   pc,
  // stats
  output logic [15:0]           stall_cnt
);

  localparam int EXT_W = DATA_W - 1 - IMM_W;

  logic                accept;
  logic [DATA_W-1:0]   va;
  logic [DATA_W-1:0]   vb;
  logic                bz;
  logic                bn;
  logic                cond;
  logic                take_ok;
  logic                inc_ok;
  logic [DATA_W-2:0]   pc_lo;
  logic [DATA_W-1:0]   pc_hi;

  logic                out_valid_d, out_valid_q;
  logic [DATA_W-1:0]   src_a_d, src_a_q;
  logic [DATA_W-1:0]   src_b_d, src_b_q;
  logic                src_a_en_d, src_a_en_q;
  logic                src_b_en_d, src_b_en_q;
  logic                alu_en_d, alu_en_q;
  logic [3:0]          tt_d, tt_q;
  logic [4:0]          op_d, op_q;
  logic [SH_W-1:0]     sh_off_d, sh_off_q;
  logic [15:0]         stall_d, stall_q;

  assign reg_a_read = read_a;
  assign reg_a      = arg_a;
  assign reg_b_read = read_b;
  assign reg_b      = arg_b;

  assign in_ready = !cpu_rst && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Operand values, branch condition, target and strobes
  always_comb begin
    va = (wb_en && (wb_reg == arg_a)) ? wb_value : reg_a_value;
    vb = (wb_en && (wb_reg == arg_b)) ? wb_value : reg_b_value;

    bz   = (vb == {DATA_W{1'b0}});
    bn   = vb[DATA_W-1];
    cond = cmp_b[2] ? (bn ^ cmp_b[1]) : (bz ^ cmp_b[1]);

    if (!pc_src[0]) begin
      pc_lo = {(DATA_W-1){1'b0}};
    end else if (read_a) begin
      pc_lo = va[DATA_W-1:1];
    end else if (imm_en) begin
      pc_lo = {{EXT_W{arg_imm[IMM_W-1]}}, arg_imm};
    end else begin
      pc_lo = {(DATA_W-1){1'b0}};
    end
    pc_hi = pc_src[1] ? vb : {DATA_W{pc_lo[DATA_W-2]}};
    pc    = {pc_hi, pc_lo};

    // cmp_b[0] selects conditional behaviour; inc fires on the not-taken side
    take_ok  = !cmp_b[0] || cond;
    inc_ok   = !cmp_b[0] || !cond;
    o_pc_set = accept && pc_set && take_ok;
    o_pc_add = accept && pc_add && take_ok;
    o_pc_inc = accept && pc_inc && inc_ok;
  end

  // Next state of the output register and stall counter
  always_comb begin
    out_valid_d = out_valid_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    src_a_en_d  = src_a_en_q;
    src_b_en_d  = src_b_en_q;
    alu_en_d    = alu_en_q;
    tt_d        = tt_q;
    op_d        = op_q;
    sh_off_d    = sh_off_q;

    if (accept) begin
      out_valid_d = 1'b1;
      src_a_d     = read_a ? va : src_a_q;
      src_b_d     = read_b ? vb : src_b_q;
      src_a_en_d  = read_a && en_regs[0];
      src_b_en_d  = read_b && en_regs[1];
      alu_en_d    = i_alu_en;
      tt_d        = i_truth_table;
      op_d        = i_alu_op;
      sh_off_d    = sh_off_imm ? arg_imm[SH_W-1:0] : va[SH_W-1:0];
    end else if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Output register and stall counter, synchronous reset
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      out_valid_q <= 1'b0;
      src_a_q     <= {DATA_W{1'b0}};
      src_b_q     <= {DATA_W{1'b0}};
      src_a_en_q  <= 1'b0;
      src_b_en_q  <= 1'b0;
      alu_en_q    <= 1'b0;
      tt_q        <= 4'd0;
      op_q        <= 5'd0;
      sh_off_q    <= {SH_W{1'b0}};
      stall_q     <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      src_a_en_q  <= src_a_en_d;
      src_b_en_q  <= src_b_en_d;
      alu_en_q    <= alu_en_d;
      tt_q        <= tt_d;
      op_q        <= op_d;
      sh_off_q    <= sh_off_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign src_a         = src_a_q;
  assign src_b         = src_b_q;
  assign src_a_en      = src_a_en_q;
  assign src_b_en      = src_b_en_q;
  assign o_alu_en      = alu_en_q;
  assign o_truth_table = tt_q;
  assign o_alu_op      = op_q;
  assign sh_off        = sh_off_q;
  assign stall_cnt     = stall_q;

endmodule

// File: doc/read_stage.md
READ_STAGE -- requirements
Module: read_stage

Interface
REQ-001 Parameter DATA_W, default 16, register/operand width (even, >=8).
REQ-002 Parameter REG_W, default 4, register index width.
REQ-003 Parameter IMM_W, default 5, immediate width (IMM_W >= SH_W).
REQ-004 Parameter SH_W, default 4, shift-offset width (2**SH_W == DATA_W).
REQ-005 Ports: cpu_clk in 1, rising-edge clock; cpu_rst in 1, reset, synchronous active-high.
REQ-006 Upstream: in_valid in 1; in_ready out 1; flush in 1, discard pipeline contents.
REQ-007 Decode inputs: imm_en 1; arg_imm IMM_W; read_a 1; arg_a REG_W; read_b 1; arg_b REG_W; cmp_b 3; pc_set 1; pc_add 1; pc_inc 1; pc_src 2; en_regs 2; i_alu_en 1; i_truth_table 4; i_alu_op 5; sh_off_imm 1.
REQ-008 Register file: reg_a_read out 1; reg_a out REG_W; reg_a_value in DATA_W; reg_b_read out 1; reg_b out REG_W; reg_b_value in DATA_W; same-cycle combinational read.
REQ-009 Writeback bypass: wb_en in 1; wb_reg in REG_W; wb_value in DATA_W.
REQ-010 Downstream: out_valid out 1; out_ready in 1; src_a_en, src_b_en out 1; src_a, src_b out DATA_W; o_alu_en out 1; o_truth_table out 4; o_alu_op out 5; sh_off out SH_W.
REQ-011 Branch: o_pc_set, o_pc_add, o_pc_inc out 1; pc out 2*DATA_W-1.
REQ-012 Stats: stall_cnt out 16, saturating count of downstream stall cycles.

Function
REQ-013 reg_a_read=read_a, reg_a=arg_a, reg_b_read=read_b, reg_b=arg_b, combinational, ungated.
REQ-014 Operand A value va = (wb_en && wb_reg==arg_a) ? wb_value : reg_a_value; vb likewise with arg_b/reg_b_value.
REQ-015 in_ready = !cpu_rst && !flush && (!out_valid || out_ready); accept = in_valid && in_ready.
REQ-016 On accept (next edge): out_valid=1; src_a=va if read_a else held; src_b=vb if read_b else held; src_a_en=read_a&en_regs[0]; src_b_en=read_b&en_regs[1]; o_alu_en, o_truth_table, o_alu_op copied; sh_off = sh_off_imm ? arg_imm[SH_W-1:0] : va[SH_W-1:0].
REQ-017 out_valid && out_ready && !accept -> out_valid=0 next edge; accept while draining -> replaced, out_valid stays 1 (zero-bubble, 1-cycle latency).
REQ-018 out_valid && !out_ready -> all registered outputs hold.
REQ-019 flush=1 -> out_valid=0 next edge regardless of out_ready; no accept that cycle; other registers hold.
REQ-020 Condition: bz = (vb==0); bn = vb[DATA_W-1]; cond = cmp_b[2] ? (bn ^ cmp_b[1]) : (bz ^ cmp_b[1]).
REQ-021 pc_lo (DATA_W-1 bits) = !pc_src[0] ? 0 : read_a ? va[DATA_W-1:1] : imm_en ? sign-extended arg_imm : 0.
REQ-022 pc_hi (DATA_W bits) = pc_src[1] ? vb : DATA_W copies of pc_lo MSB; pc = {pc_hi, pc_lo}.
REQ-023 o_pc_set = accept & pc_set & (!cmp_b[0] | cond); o_pc_add = accept & pc_add & (!cmp_b[0] | cond); o_pc_inc = accept & pc_inc & (!cmp_b[0] | !cond); combinational.
REQ-024 stall_cnt increments by 1 each cycle out_valid && !out_ready, saturates at 16'hFFFF; unaffected by flush.
REQ-025 Bypass priority: wb match wins even when wb_value equals reg value; no match when wb_en=0.

Reset
REQ-026 cpu_rst=1 at edge -> out_valid, src_a_en, src_b_en, o_alu_en, src_a, src_b, o_truth_table, o_alu_op, sh_off, stall_cnt all 0.
REQ-027 While cpu_rst=1: in_ready=0, branch strobes 0, no accept; reset mid-stall drops held entry.
REQ-028 First accept possible the cycle after cpu_rst deasserts.

Verification
REQ-029 DATA_W=16: read_a, arg_a=3, reg_a_value=16'h1234, en_regs=01, out_ready=1 -> next cycle out_valid=1, src_a=16'h1234, src_a_en=1, src_b_en=0.
REQ-030 Bypass: arg_b=5, wb_en=1, wb_reg=5, wb_value=16'hBEEF, reg_b_value=0 -> src_b=16'hBEEF; cmp_b=001, pc_set=1 -> o_pc_set=0 (vb nonzero).
REQ-031 Branch: pc_src=01, imm_en=1, read_a=0, arg_imm=5'b11110, pc_add=1, cmp_b=000 -> pc=31'h7FFFFFFE, o_pc_add=1 in accept cycle.
REQ-032 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs hold, stall_cnt=3; out_ready=1 with in_valid=1 -> new data next cycle, no bubble.
REQ-033 flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle, in_ready=0 during flush cycle, strobes 0.
REQ-034 cpu_rst during stall with stall_cnt=16'hFFFF -> all outputs 0 next cycle; prior saturation verified with no wrap.
